// File: rtl/ch_unit_pkg.sv
// Shared constants and FSM state encoding for ch_unit and its RAM loader.
package ch_unit_pkg;

    localparam int CH_ADDR_W    = 20;
    localparam int CH_WORD_W    = 32;
    localparam int CH_RAM_DEPTH = 1048576;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_WORD = 4'd1,
        ST_ADDR      = 4'd2,
        ST_ADDR_GAP  = 4'd3,
        ST_DATA      = 4'd4,
        ST_DATA_GAP  = 4'd5,
        ST_STOP      = 4'd6,
        ST_STOP_GAP  = 4'd7,
        ST_DONE      = 4'd8
    } ch_state_e;

endpackage

// File: rtl/ch_bit_serializer.sv
// Word shift register emitting bits LSB first; last_bit flags that the
// bit currently at position 0 is the final one of the loaded word.
module ch_bit_serializer #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    output logic              bit_out,
    output logic              last_bit
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] data_r;
    logic [IDX_W-1:0]  idx_r;

    // Shift register and consumed-bit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
            idx_r  <= '0;
        end else if (load) begin
            data_r <= word;
            idx_r  <= '0;
        end else if (shift) begin
            data_r <= {1'b0, data_r[WORD_W-1:1]};
            idx_r  <= idx_r + IDX_W'(1);
        end else begin
            data_r <= data_r;
            idx_r  <= idx_r;
        end
    end

    assign bit_out  = data_r[0];
    assign last_bit = (idx_r == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/ch_ram_loader.sv
// Streams 32-bit words bit-serially into ch_unit's GPIO RAM write port,
// then programs the stop address for the job.
module ch_ram_loader
    import ch_unit_pkg::*;
#(
    parameter int ADDR_W    = CH_ADDR_W,
    parameter int RAM_DEPTH = CH_RAM_DEPTH,
    parameter int WORD_W    = CH_WORD_W
) (
    input  logic              s_axi_clk,
    input  logic              s_axi_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_bit_count,
    input  logic              i_abort,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_word_valid,
    output logic              o_word_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic              o_mode,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_write_addr,
    output logic              o_din,
    output logic              o_write_ram,
    output logic [ADDR_W-1:0] o_stop_addr,
    output logic              o_write_stop_addr
);

    localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W+2)'(RAM_DEPTH);

    ch_state_e         state_r, state_next;
    logic [ADDR_W-1:0] base_r, addr_r, addr_next, stop_addr_s;
    logic [ADDR_W:0]   count_r, rem_r, rem_next;
    logic [ADDR_W+1:0] job_end_s;
    logic              load_s, shift_s, bit_s, last_bit_s, range_bad_s, accept_s;

    assign job_end_s   = {2'b00, i_base_addr} + {1'b0, i_bit_count};
    assign range_bad_s = (job_end_s > DEPTH_EXT);
    assign accept_s    = (state_r == ST_IDLE) && i_start;
    // count_r may equal RAM_DEPTH; the truncated sum still yields the last address.
    assign stop_addr_s = base_r + count_r[ADDR_W-1:0] - ADDR_W'(1);

    ch_bit_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk      (s_axi_clk),
        .rst      (s_axi_reset),
        .load     (load_s),
        .shift    (shift_s),
        .word     (i_word),
        .bit_out  (bit_s),
        .last_bit (last_bit_s)
    );

    // Next-state, counter and serializer control.
    always_comb begin
        state_next = state_r;
        addr_next  = addr_r;
        rem_next   = rem_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!i_start) begin
                    state_next = ST_IDLE;
                end else if (i_bit_count == '0) begin
                    state_next = ST_DONE;
                end else if (range_bad_s) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WAIT_WORD;
                    addr_next  = i_base_addr;
                    rem_next   = i_bit_count;
                end
            end
            ST_WAIT_WORD: begin
                if (i_word_valid) begin
                    load_s     = 1'b1;
                    state_next = ST_ADDR;
                end else begin
                    state_next = ST_WAIT_WORD;
                end
            end
            ST_ADDR:     state_next = ST_ADDR_GAP;
            ST_ADDR_GAP: state_next = ST_DATA;
            ST_DATA:     state_next = ST_DATA_GAP;
            ST_DATA_GAP: begin
                shift_s   = 1'b1;
                addr_next = addr_r + ADDR_W'(1);
                rem_next  = rem_r - (ADDR_W+1)'(1);
                if (rem_r == (ADDR_W+1)'(1)) begin
                    state_next = ST_STOP;
                end else if (last_bit_s) begin
                    state_next = ST_WAIT_WORD;
                end else begin
                    state_next = ST_ADDR;
                end
            end
            ST_STOP:     state_next = ST_STOP_GAP;
            ST_STOP_GAP: state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
        if (i_abort && (state_r != ST_IDLE)) begin
            state_next = ST_IDLE;
            load_s     = 1'b0;
            shift_s    = 1'b0;
        end else begin
            state_next = state_next;
        end
    end

    // State, job registers and outputs registered from the next state.
    always_ff @(posedge s_axi_clk or posedge s_axi_reset) begin
        if (s_axi_reset) begin
            state_r           <= ST_IDLE;
            addr_r            <= '0;
            rem_r             <= '0;
            base_r            <= '0;
            count_r           <= '0;
            o_error           <= 1'b0;
            o_busy            <= 1'b0;
            o_mode            <= 1'b0;
            o_word_ready      <= 1'b0;
            o_write_addr      <= 1'b0;
            o_write_ram       <= 1'b0;
            o_write_stop_addr <= 1'b0;
            o_done            <= 1'b0;
            o_ram_addr        <= '0;
            o_din             <= 1'b0;
            o_stop_addr       <= '0;
        end else begin
            state_r           <= state_next;
            addr_r            <= addr_next;
            rem_r             <= rem_next;
            if (accept_s) begin
                base_r  <= i_base_addr;
                count_r <= i_bit_count;
                o_error <= range_bad_s;
            end
            o_busy            <= (state_next != ST_IDLE);
            o_mode            <= (state_next != ST_IDLE);
            o_word_ready      <= (state_next == ST_WAIT_WORD);
            o_write_addr      <= (state_next == ST_ADDR);
            o_write_ram       <= (state_next == ST_DATA);
            o_write_stop_addr <= (state_next == ST_STOP);
            o_done            <= (state_next == ST_DONE);
            if (state_next == ST_ADDR) begin
                o_ram_addr <= addr_next;
            end
            if (state_next == ST_DATA) begin
                o_din <= bit_s;
            end
            if (state_next == ST_STOP) begin
                o_stop_addr <= stop_addr_s;
            end
        end
    end

endmodule

// File: tb/tb_ch_ram_loader.sv
// Directed bench for ch_ram_loader: a negedge monitor logs every strobe and
// each job is checked against hand-computed addresses, bits and stop address.
module tb_ch_ram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0, i_abort = 1'b0, i_word_valid = 1'b0;
    logic [19:0] i_base_addr = 20'd0;
    logic [20:0] i_bit_count = 21'd0;
    logic [31:0] i_word = 32'd0;
    logic        o_word_ready, o_busy, o_done, o_error, o_mode;
    logic [19:0] o_ram_addr, o_stop_addr;
    logic        o_write_addr, o_din, o_write_ram, o_write_stop_addr;

    ch_ram_loader dut (
        .s_axi_clk(clk), .s_axi_reset(rst), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_bit_count(i_bit_count), .i_abort(i_abort),
        .i_word(i_word), .i_word_valid(i_word_valid), .o_word_ready(o_word_ready),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_mode(o_mode),
        .o_ram_addr(o_ram_addr), .o_write_addr(o_write_addr), .o_din(o_din),
        .o_write_ram(o_write_ram), .o_stop_addr(o_stop_addr),
        .o_write_stop_addr(o_write_stop_addr)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic [19:0] wa_addr_q[$];
    int          wa_cyc_q[$];
    logic        din_q[$];
    int          stop_cnt = 0, done_cnt = 0, hs_cnt = 0, hs_cyc = 0;
    logic [19:0] last_stop = 20'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_write_addr) begin
            wa_addr_q.push_back(o_ram_addr);
            wa_cyc_q.push_back(cyc);
        end
        if (o_write_ram) din_q.push_back(o_din);
        if (o_write_stop_addr) begin
            stop_cnt  <= stop_cnt + 1;
            last_stop <= o_stop_addr;
        end
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_word_ready && i_word_valid) begin
            hs_cnt <= hs_cnt + 1;
            hs_cyc <= cyc;
        end
    end

    int errors = 0, checks = 0;
    int s_wa, s_din, s_stop, s_done, s_hs, stall_bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({o_word_ready, o_busy, o_done, o_error, o_mode, o_ram_addr,
                    o_write_addr, o_din, o_write_ram, o_stop_addr, o_write_stop_addr});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_wa   = wa_addr_q.size();
        s_din  = din_q.size();
        s_stop = stop_cnt;
        s_done = done_cnt;
        s_hs   = hs_cnt;
    endtask

    task automatic start_job(input logic [19:0] base, input logic [20:0] count);
        i_base_addr = base;
        i_bit_count = count;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic send_word(input string tag, input logic [31:0] w, input int stall, input bit keep);
        bit ok = 1'b0;
        int n = 0;
        if (stall > 0) begin
            while (!o_word_ready && n < 1000) begin
                tick();
                n++;
            end
            for (int i = 0; i < stall; i++) begin
                if (!o_word_ready || o_write_addr || o_write_ram || o_write_stop_addr) stall_bad++;
                tick();
            end
        end
        i_word       = w;
        i_word_valid = 1'b1;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (o_word_ready) ok = 1'b1;
            tick();
        end
        check({tag, ".handshake"}, 64'(ok), 64'd1);
        if (!keep) i_word_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (o_done) ok = 1'b1;
            tick();
        end
        check({tag, ".done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic check_job(input string tag, input logic [19:0] base, input logic [20:0] count,
                             input logic [63:0] exp_din, input int exp_hs);
        int          nwa  = wa_addr_q.size() - s_wa;
        int          ndin = din_q.size() - s_din;
        int          bad  = 0;
        logic [63:0] dv   = 64'd0;
        check({tag, ".n_addr"}, 64'(nwa), 64'(count));
        check({tag, ".n_din"}, 64'(ndin), 64'(count));
        for (int i = 0; i < nwa; i++)
            if (wa_addr_q[s_wa + i] !== 20'(base + 20'(i))) bad++;
        check({tag, ".addr_seq"}, 64'(bad), 64'd0);
        for (int i = 0; i < ndin && i < 64; i++) dv[i] = din_q[s_din + i];
        check({tag, ".din_bits"}, dv, exp_din);
        check({tag, ".n_stop"}, 64'(stop_cnt - s_stop), 64'd1);
        check({tag, ".stop_addr"}, 64'(last_stop), 64'(base) + 64'(count) - 64'd1);
        check({tag, ".n_done"}, 64'(done_cnt - s_done), 64'd1);
        check({tag, ".n_ready_hs"}, 64'(hs_cnt - s_hs), 64'(exp_hs));
    endtask

    initial begin
        int bad, n, g;
        repeat (2) @(posedge clk);
        #1;
        check("reset.outputs", outs(), 64'd0);
        rst = 1'b0;
        tick();

        // Single full word, LSB-first, timing
        snap();
        start_job(20'd0, 21'd32);
        check("t1.busy_mode", 64'({o_busy, o_mode}), 64'd3);
        send_word("t1", 32'hA5A5A5A5, 0, 1'b0);
        wait_done("t1");
        check_job("t1", 20'd0, 21'd32, 64'hA5A5A5A5, 1);
        if (wa_addr_q.size() >= s_wa + 32) begin
            check("t1.latency", 64'(wa_cyc_q[s_wa] - hs_cyc), 64'd1);
            check("t1.throughput", 64'(wa_cyc_q[s_wa + 31] - wa_cyc_q[s_wa]), 64'd124);
        end else begin
            check("t1.addr_count", 64'(wa_addr_q.size() - s_wa), 64'd32);
        end
        check("t1.idle_busy_mode", 64'({o_busy, o_mode}), 64'd0);

        // Partial second word; valid stays high so any third ready would be seen
        snap();
        start_job(20'd100, 21'd40);
        send_word("t2a", 32'hFFFFFFFF, 0, 1'b0);
        send_word("t2b", 32'h000000F0, 0, 1'b1);
        i_word = 32'hDEADBEEF;
        wait_done("t2");
        repeat (3) tick();
        i_word_valid = 1'b0;
        check_job("t2", 20'd100, 21'd40, 64'h000000F0FFFFFFFF, 2);

        // Out-of-range job, then one ending exactly at RAM_DEPTH
        snap();
        start_job(20'hFFFF0, 21'd32);
        check("t3.error_set", 64'(o_error), 64'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_busy || o_mode || o_word_ready || o_write_addr || o_write_ram ||
                o_write_stop_addr || o_done) bad++;
            tick();
        end
        check("t3.quiet", 64'(bad), 64'd0);
        check("t3.error_sticky", 64'(o_error), 64'd1);
        check("t3.no_done", 64'(done_cnt - s_done), 64'd0);
        snap();
        start_job(20'hFFFF0, 21'd16);
        check("t3.error_cleared", 64'(o_error), 64'd0);
        send_word("t3b", 32'h0000BEEF, 0, 1'b0);
        wait_done("t3b");
        check_job("t3b", 20'hFFFF0, 21'd16, 64'h000000000000BEEF, 1);

        // Zero-length job
        snap();
        start_job(20'd123, 21'd0);
        wait_done("t0");
        check("t0.no_writes", 64'(wa_addr_q.size() - s_wa + stop_cnt - s_stop), 64'd0);
        check("t0.no_ready", 64'(hs_cnt - s_hs), 64'd0);
        check("t0.one_done", 64'(done_cnt - s_done), 64'd1);

        // Input stall before the second word
        snap();
        stall_bad = 0;
        start_job(20'd200, 21'd64);
        send_word("t4a", 32'h12345678, 0, 1'b0);
        send_word("t4b", 32'h9ABCDEF0, 20, 1'b0);
        check("t4.stall", 64'(stall_bad), 64'd0);
        wait_done("t4");
        check_job("t4", 20'd200, 21'd64, 64'h9ABCDEF012345678, 2);

        // Abort in DATA of bit 5, with a competing start
        snap();
        start_job(20'd0, 21'd32);
        send_word("t5", 32'hFFFFFFFF, 0, 1'b0);
        n = 0;
        g = 0;
        while (g < 1000) begin
            if (o_write_ram) n++;
            if (n == 6) break;
            tick();
            g++;
        end
        check("t5.reach_bit5", 64'(n), 64'd6);
        i_abort     = 1'b1;
        i_start     = 1'b1;
        i_base_addr = 20'd700;
        i_bit_count = 21'd4;
        tick();
        i_abort = 1'b0;
        i_start = 1'b0;
        check("t5.after_abort", 64'({o_busy, o_mode, o_word_ready, o_write_addr, o_write_ram,
                                     o_write_stop_addr, o_done}), 64'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_busy || o_write_addr || o_write_ram) bad++;
            tick();
        end
        check("t5.start_dropped", 64'(bad), 64'd0);
        check("t5.bits_written", 64'(din_q.size() - s_din), 64'd6);
        check("t5.no_done_stop", 64'(done_cnt - s_done + stop_cnt - s_stop), 64'd0);
        check("t5.error_kept", 64'(o_error), 64'd0);
        snap();
        start_job(20'd50, 21'd8);
        send_word("t5b", 32'h0000005A, 0, 1'b0);
        wait_done("t5b");
        check_job("t5b", 20'd50, 21'd8, 64'h5A, 1);

        // Start while busy is ignored
        snap();
        start_job(20'd300, 21'd32);
        send_word("t6", 32'hC3C3C3C3, 0, 1'b0);
        repeat (10) tick();
        start_job(20'd700, 21'd4);
        wait_done("t6");
        check_job("t6", 20'd300, 21'd32, 64'hC3C3C3C3, 1);

        // Asynchronous reset mid-job
        snap();
        start_job(20'd400, 21'd32);
        send_word("t7", 32'hFFFFFFFF, 0, 1'b0);
        repeat (10) tick();
        #2 rst = 1'b1;
        #1 check("t7.async_reset", outs(), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick();
        check("t7.no_side_effects", 64'(done_cnt - s_done + stop_cnt - s_stop), 64'd0);
        snap();
        start_job(20'd10, 21'd4);
        send_word("t7b", 32'h00000009, 0, 1'b0);
        wait_done("t7b");
        check_job("t7b", 20'd10, 21'd4, 64'h9, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
